// File: rtl/inspeccion_multicanal.sv
// Multi-channel part inspection: one Moore FSM per channel feeding a single
// round-robin arbitrated verdict register with saturating accept/reject stats.

module inspeccion_canal #(
    parameter int PASS_REQ = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p,
    input  logic       ri,
    input  logic       grant,
    output logic [1:0] status
);
    typedef enum logic [1:0] {IDLE = 2'b00, INSP = 2'b01, REJ = 2'b10, ACC = 2'b11} state_t;

    localparam logic [3:0] PASS_N = 4'(PASS_REQ);

    state_t     state, state_nx;
    logic [3:0] pass_cnt, pass_cnt_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pass_cnt <= '0;
        end else begin
            state    <= state_nx;
            pass_cnt <= pass_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pass_cnt_nx = pass_cnt;
        case (state)
            IDLE: if (p) begin
                state_nx    = INSP;
                pass_cnt_nx = '0;
            end
            INSP: begin
                if (!p)
                    state_nx = IDLE;
                else if (!ri)
                    state_nx = REJ;
                else begin
                    pass_cnt_nx = pass_cnt + 4'd1;
                    if (pass_cnt_nx == PASS_N) state_nx = ACC;
                end
            end
            // Verdict pending: P and RI are ignored until the arbiter takes it.
            REJ, ACC: if (grant) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign status = state;
endmodule

module inspeccion_multicanal #(
    parameter int N_CH     = 4,
    parameter int PASS_REQ = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   P,
    input  logic [N_CH-1:0]   RI,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [2:0]        result_ch,
    output logic [1:0]        result_code,
    output logic [2*N_CH-1:0] ch_status,
    output logic [CNT_W-1:0]  acc_count,
    output logic [CNT_W-1:0]  rej_count
);
    localparam int         IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW:0] NCH = (IW+1)'(N_CH);

    logic [N_CH-1:0][1:0] st;
    logic [N_CH-1:0]      pend, grant;
    logic [IW-1:0]        rr_ptr, gnt_idx;
    logic [IW:0]          sum;
    logic                 found, load, xfer;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign pend[k]  = st[k][1];
        assign grant[k] = load && (gnt_idx == IW'(k));
        inspeccion_canal #(.PASS_REQ(PASS_REQ)) u_ch (
            .clk(clk), .reset(reset), .p(P[k]), .ri(RI[k]),
            .grant(grant[k]), .status(st[k])
        );
    end

    // First pending channel scanning upward from rr_ptr, wrapping at N_CH.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= NCH) sum = sum - NCH;
            if (!found && pend[sum[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[IW-1:0];
            end
        end
    end

    assign load      = (!result_valid || result_ready) && found;
    assign xfer      = result_valid && result_ready;
    assign ch_status = st;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr       <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_code  <= '0;
            acc_count    <= '0;
            rej_count    <= '0;
        end else begin
            if (load) begin
                result_valid <= 1'b1;
                result_ch    <= 3'(gnt_idx);
                result_code  <= {1'b1, st[gnt_idx][0]};
                rr_ptr       <= (gnt_idx == IW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
            end else if (xfer) begin
                result_valid <= 1'b0;
            end
            if (xfer && result_code == 2'b11 && acc_count != '1) acc_count <= acc_count + 1'b1;
            if (xfer && result_code == 2'b10 && rej_count != '1) rej_count <= rej_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_inspeccion_multicanal.sv
// Directed bench: main instance with default parameters, second instance with
// 2-bit counters for the saturation case.

module tb_inspeccion_multicanal;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] P, RI, P2, RI2;
    logic       result_ready, ready2;
    logic       result_valid, valid2;
    logic [2:0] result_ch, ch2;
    logic [1:0] result_code, code2;
    logic [7:0] ch_status, status2;
    logic [7:0] acc_count, rej_count;
    logic [1:0] acc2, rej2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inspeccion_multicanal #(.N_CH(4), .PASS_REQ(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .P(P), .RI(RI),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_ch(result_ch), .result_code(result_code),
        .ch_status(ch_status), .acc_count(acc_count), .rej_count(rej_count)
    );

    inspeccion_multicanal #(.N_CH(4), .PASS_REQ(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .P(P2), .RI(RI2),
        .result_valid(valid2), .result_ready(ready2),
        .result_ch(ch2), .result_code(code2),
        .ch_status(status2), .acc_count(acc2), .rej_count(rej2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; P = '0; RI = '0; result_ready = 1'b1;
        P2 = '0; RI2 = '0; ready2 = 1'b0;
        tick(); tick();
        n_vec++;
        if ({result_valid, result_ch, result_code} !== 6'b0) begin
            n_bad++; $display("FAIL reset_out got %b want 000000", {result_valid, result_ch, result_code});
        end
        n_vec++;
        if ({ch_status, acc_count, rej_count} !== 24'h0) begin
            n_bad++; $display("FAIL reset_state got %h want 000000", {ch_status, acc_count, rej_count});
        end
        reset = 1'b1;
    endtask

    task automatic test_accept();
        logic [1:0] exp_st [3];
        exp_st[0] = 2'b01; exp_st[1] = 2'b01; exp_st[2] = 2'b11;
        P = 4'b0001; RI = 4'b0001; result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (ch_status[1:0] !== exp_st[i]) begin
                n_bad++; $display("FAIL accept_status%0d got %b want %b", i, ch_status[1:0], exp_st[i]);
            end
        end
        n_vec++;
        if (result_valid !== 1'b0) begin
            n_bad++; $display("FAIL accept_early_valid got %b want 0", result_valid);
        end
        P = '0; RI = '0;
        tick();
        n_vec++;
        if ({result_valid, result_ch, result_code, ch_status, acc_count} !== {1'b1, 3'd0, 2'b11, 8'h00, 8'd0}) begin
            n_bad++; $display("FAIL accept_verdict got v%b ch%0d c%b st%h acc%0d want v1 ch0 c11 st00 acc0",
                              result_valid, result_ch, result_code, ch_status, acc_count);
        end
        tick();
        n_vec++;
        if ({result_valid, acc_count, rej_count} !== {1'b0, 8'd1, 8'd0}) begin
            n_bad++; $display("FAIL accept_count got v%b acc%0d rej%0d want v0 acc1 rej0", result_valid, acc_count, rej_count);
        end
    endtask

    task automatic test_reject_abort();
        P = 4'b0010; RI = 4'b0000;
        tick(); tick();
        n_vec++;
        if (ch_status !== 8'h08) begin
            n_bad++; $display("FAIL reject_status got %h want 08", ch_status);
        end
        P = '0;
        tick();
        n_vec++;
        if ({result_valid, result_ch, result_code} !== {1'b1, 3'd1, 2'b10}) begin
            n_bad++; $display("FAIL reject_verdict got v%b ch%0d c%b want v1 ch1 c10", result_valid, result_ch, result_code);
        end
        tick();
        n_vec++;
        if ({result_valid, acc_count, rej_count} !== {1'b0, 8'd1, 8'd1}) begin
            n_bad++; $display("FAIL reject_count got v%b acc%0d rej%0d want v0 acc1 rej1", result_valid, acc_count, rej_count);
        end
        P = 4'b0100;
        tick();
        n_vec++;
        if (ch_status !== 8'h10) begin
            n_bad++; $display("FAIL abort_insp got %h want 10", ch_status);
        end
        P = '0;
        tick();
        n_vec++;
        if (ch_status !== 8'h00) begin
            n_bad++; $display("FAIL abort_idle got %h want 00", ch_status);
        end
        tick();
        n_vec++;
        if ({result_valid, acc_count, rej_count} !== {1'b0, 8'd1, 8'd1}) begin
            n_bad++; $display("FAIL abort_no_verdict got v%b acc%0d rej%0d want v0 acc1 rej1", result_valid, acc_count, rej_count);
        end
    endtask

    task automatic all_four_then_drain(input logic [2:0] first, input logic [7:0] acc_base, input string tag);
        logic [2:0] exp_ch;
        P = 4'b1111; RI = 4'b1111;
        tick(); tick(); tick();
        n_vec++;
        if (ch_status !== 8'hFF) begin
            n_bad++; $display("FAIL %s_all_acc got %h want ff", tag, ch_status);
        end
        P = '0; RI = '0;
        exp_ch = first;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({result_valid, result_ch, result_code, acc_count} !== {1'b1, exp_ch, 2'b11, acc_base + 8'(i)}) begin
                n_bad++; $display("FAIL %s_order%0d got v%b ch%0d c%b acc%0d want v1 ch%0d c11 acc%0d",
                                  tag, i, result_valid, result_ch, result_code, acc_count, exp_ch, acc_base + 8'(i));
            end
            exp_ch = (exp_ch == 3'd3) ? 3'd0 : exp_ch + 3'd1;
        end
        tick();
        n_vec++;
        if ({result_valid, acc_count} !== {1'b0, acc_base + 8'd4}) begin
            n_bad++; $display("FAIL %s_drain got v%b acc%0d want v0 acc%0d", tag, result_valid, acc_count, acc_base + 8'd4);
        end
    endtask

    task automatic test_arbitration();
        reset = 1'b0; P = '0; RI = '0;
        tick();
        reset = 1'b1; result_ready = 1'b1;
        all_four_then_drain(3'd0, 8'd0, "arb_first");
        // single ch1 verdict moves the pointer to 2
        P = 4'b0010; RI = 4'b0010;
        tick(); tick(); tick();
        P = '0; RI = '0;
        tick();
        n_vec++;
        if ({result_valid, result_ch} !== {1'b1, 3'd1}) begin
            n_bad++; $display("FAIL arb_single got v%b ch%0d want v1 ch1", result_valid, result_ch);
        end
        tick();
        all_four_then_drain(3'd2, 8'd5, "arb_resume");
    endtask

    task automatic test_backpressure();
        result_ready = 1'b0;
        P = 4'b0011; RI = 4'b0001;
        tick(); tick();
        n_vec++;
        if (ch_status !== 8'h09) begin
            n_bad++; $display("FAIL bp_status got %h want 09", ch_status);
        end
        P = 4'b0001;
        tick();
        P = '0; RI = '0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({result_valid, result_ch, result_code, ch_status, acc_count, rej_count} !==
                {1'b1, 3'd1, 2'b10, 8'h03, 8'd9, 8'd0}) begin
                n_bad++; $display("FAIL bp_hold%0d got v%b ch%0d c%b st%h acc%0d rej%0d want v1 ch1 c10 st03 acc9 rej0",
                                  i, result_valid, result_ch, result_code, ch_status, acc_count, rej_count);
            end
            tick();
        end
        result_ready = 1'b1;
        tick();
        n_vec++;
        if ({result_valid, result_ch, result_code, ch_status, rej_count} !== {1'b1, 3'd0, 2'b11, 8'h00, 8'd1}) begin
            n_bad++; $display("FAIL bp_release got v%b ch%0d c%b st%h rej%0d want v1 ch0 c11 st00 rej1",
                              result_valid, result_ch, result_code, ch_status, rej_count);
        end
        tick();
        n_vec++;
        if ({result_valid, acc_count} !== {1'b0, 8'd10}) begin
            n_bad++; $display("FAIL bp_drain got v%b acc%0d want v0 acc10", result_valid, acc_count);
        end
    endtask

    task automatic test_saturation();
        ready2 = 1'b1;
        P2 = 4'b1111; RI2 = 4'b1111;
        tick(); tick(); tick();
        P2 = '0; RI2 = '0;
        repeat (5) tick();
        n_vec++;
        if ({valid2, acc2, rej2} !== {1'b0, 2'd3, 2'd0}) begin
            n_bad++; $display("FAIL sat_four got v%b acc%0d rej%0d want v0 acc3 rej0", valid2, acc2, rej2);
        end
        P2 = 4'b0001; RI2 = 4'b0001;
        tick(); tick(); tick();
        P2 = '0; RI2 = '0;
        tick();
        n_vec++;
        if ({valid2, code2} !== {1'b1, 2'b11}) begin
            n_bad++; $display("FAIL sat_fifth got v%b c%b want v1 c11", valid2, code2);
        end
        tick();
        n_vec++;
        if (acc2 !== 2'd3) begin
            n_bad++; $display("FAIL sat_hold got %0d want 3", acc2);
        end
    endtask

    task automatic test_reset_mid();
        result_ready = 1'b0;
        P = 4'b0111; RI = 4'b0111;
        tick(); tick(); tick();
        P = '0; RI = '0;
        tick();
        n_vec++;
        if ({result_valid, result_ch, ch_status} !== {1'b1, 3'd1, 8'h33}) begin
            n_bad++; $display("FAIL mid_setup got v%b ch%0d st%h want v1 ch1 st33", result_valid, result_ch, ch_status);
        end
        reset = 1'b0; result_ready = 1'b1;
        tick();
        n_vec++;
        if ({result_valid, result_ch, result_code, ch_status, acc_count, rej_count} !== 30'h0) begin
            n_bad++; $display("FAIL mid_reset got v%b ch%0d c%b st%h acc%0d rej%0d want all zero",
                              result_valid, result_ch, result_code, ch_status, acc_count, rej_count);
        end
        reset = 1'b1;
        tick(); tick();
        n_vec++;
        if ({result_valid, ch_status, acc_count, rej_count} !== 25'h0) begin
            n_bad++; $display("FAIL mid_discard got v%b st%h acc%0d rej%0d want all zero",
                              result_valid, ch_status, acc_count, rej_count);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject_abort();
        test_arbitration();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/inspeccion_multicanal.md
INSPECCION_MULTICANAL -- requirements
Module: inspeccion_multicanal

Interface
REQ-001 Parameter N_CH, default 4, number of independent inspection channels; legal 1..8.
REQ-002 Parameter PASS_REQ, default 2, consecutive RI=1 samples required for accept; legal 1..15.
REQ-003 Parameter CNT_W, default 8, width of the accept/reject statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 P  input  N_CH  per-channel part-present flag.
REQ-007 RI  input  N_CH  per-channel inspection-pass flag, valid while P=1.
REQ-008 result_valid  output  1  verdict available in output register.
REQ-009 result_ready  input  1  consumer accepts verdict; transfer when valid&&ready at clk edge.
REQ-010 result_ch  output  3  channel index of the held verdict.
REQ-011 result_code  output  2  held verdict: 2'b10 reject, 2'b11 accept.
REQ-012 ch_status  output  2*N_CH  per-channel status, channel k at bits [2k+1:2k]: 00 idle, 01 inspecting, 10 reject pending, 11 accept pending.
REQ-013 acc_count  output  CNT_W  number of accept verdicts transferred.
REQ-014 rej_count  output  CNT_W  number of reject verdicts transferred.

Function
REQ-015 Each channel SHALL run an independent Moore FSM with states IDLE, INSP, REJ, ACC; ch_status is a pure function of state (IDLE 00, INSP 01, REJ 10, ACC 11).
REQ-016 IDLE: P=1 -> INSP with pass counter cleared; P=0 -> stay.
REQ-017 INSP: P=0 -> IDLE, no verdict, counters unchanged (abort); P=1,RI=0 -> REJ; P=1,RI=1 -> increment pass counter, and -> ACC when incremented count equals PASS_REQ, else stay INSP.
REQ-018 With PASS_REQ=2 a channel SHALL reach ACC two cycles after entering INSP when RI=1 on both cycles.
REQ-019 REJ/ACC are pending states; channel SHALL remain there, ignoring P and RI, until granted.
REQ-020 Output register load condition: (!result_valid || result_ready) and at least one channel pending; a load is the grant.
REQ-021 Grant selection SHALL be round-robin: first pending channel found searching upward from rr_ptr with wrap at N_CH; after granting channel k, rr_ptr = (k+1) mod N_CH.
REQ-022 On grant, the granted channel SHALL move to IDLE on the same edge; P is re-sampled from the next cycle.
REQ-023 result_valid SHALL assert the cycle after a channel enters REJ/ACC when the output register is free (one-cycle verdict latency).
REQ-024 While result_valid=1 and result_ready=0, result_ch and result_code SHALL hold stable and no new grant occurs.
REQ-025 valid&&ready with another channel pending SHALL reload back-to-back (no bubble); with none pending, result_valid deasserts next cycle.
REQ-026 acc_count/rej_count SHALL increment by 1 on each transfer (valid&&ready) of the matching code and saturate at 2^CNT_W-1.
REQ-027 Only one verdict transfers per cycle; simultaneous pending channels are serialised per REQ-021.

Reset
REQ-028 While reset=0 at a clk edge: all channels IDLE, pass counters 0, rr_ptr 0, result_valid 0, result_ch 0, result_code 00, acc_count 0, rej_count 0, ch_status all 00.
REQ-029 Reset mid-operation SHALL discard pending and held verdicts without counting them; result_ready is ignored during reset.

Verification
REQ-030 Accept path: N_CH=4, PASS_REQ=2, ch0 P=1 RI=1 for 3 cycles, ready=1 -> ch_status[1:0] 01,01,11, then result_valid=1, result_ch=0, code 11, acc_count=1.
REQ-031 Reject and abort: ch1 P=1 then RI=0 -> code 10, rej_count=1; ch2 P=1 one cycle then P=0 -> ch2 back to 00, no verdict, counts unchanged.
REQ-032 Arbitration: ch0..ch3 all reach ACC same cycle, ready=1 -> result_ch 0,1,2,3 on consecutive cycles, acc_count=4; repeat -> order resumes from rr_ptr.
REQ-033 Backpressure: verdict held with ready=0 for 5 cycles -> result_ch/code stable, other pending channels stay 10/11, no count change until ready=1.
REQ-034 Saturation: CNT_W=2, 5 accepted transfers -> acc_count=3.
REQ-035 Reset mid-operation: reset=0 while result_valid=1 and two channels pending -> next cycle all outputs per REQ-028.
